avr_gpio_port: RTL and testbench

- Memory-mapped GPIO port peripheral inside avr_soc; responder on the CPU I/O bus (the CPU is the initiator).
- Drives the port/ddr pad outputs and samples the pad inputs through a 2-flop synchronizer.
- AVR semantics: a write of 1 to a PIN bit toggles the matching PORT bit.
- Adds a masked pin-change interrupt flag with a level interrupt output.

---
 rtl/avr_gpio_port_pkg.sv | 30 +++
 rtl/avr_gpio_port_if.sv | 29 ++
 rtl/avr_gpio_port_sync.sv | 31 +++
 rtl/avr_gpio_port.sv | 114 +++++++++++
 tb/tb_avr_gpio_port.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/avr_gpio_port_pkg.sv
// rtl/avr_gpio_port_pkg.sv - I/O address map and register decode types for the GPIO port
package avr_gpio_port_pkg;

    localparam logic [5:0] PINB_ADDR  = 6'h16;
    localparam logic [5:0] DDRB_ADDR  = 6'h17;
    localparam logic [5:0] PORTB_ADDR = 6'h18;

    localparam logic [5:0] PIN_OFS   = 6'd0;
    localparam logic [5:0] DDR_OFS   = 6'd1;
    localparam logic [5:0] PORT_OFS  = 6'd2;
    localparam logic [5:0] PCMSK_OFS = 6'd3;
    localparam logic [5:0] PCFR_OFS  = 6'd4;
    localparam logic [5:0] NUM_REGS  = 6'd5;

    localparam int PCFR_PCIF_BIT = 0;

    typedef enum logic [2:0] {
        REG_PIN   = 3'd0,
        REG_DDR   = 3'd1,
        REG_PORT  = 3'd2,
        REG_PCMSK = 3'd3,
        REG_PCFR  = 3'd4
    } io_reg_e;

    // Offset is addr - base in 6-bit arithmetic, so addresses below base wrap high and miss.
    function automatic logic reg_hit(input logic [5:0] offset);
        return offset < NUM_REGS;
    endfunction

endpackage

// File: rtl/avr_gpio_port_if.sv
// rtl/avr_gpio_port_if.sv - CPU I/O bus between the core (master) and a peripheral (slave)
interface avr_gpio_port_if;

    logic [5:0] io_addr;
    logic       io_re;
    logic       io_we;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_sel;

    modport master (
        output io_addr,
        output io_re,
        output io_we,
        output io_wdata,
        input  io_rdata,
        input  io_sel
    );

    modport slave (
        input  io_addr,
        input  io_re,
        input  io_we,
        input  io_wdata,
        output io_rdata,
        output io_sel
    );

endinterface

// File: rtl/avr_gpio_port_sync.sv
// rtl/avr_gpio_port_sync.sv - WIDTH-bit two-flop synchronizer for asynchronous inputs
module avr_gpio_port_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign sync_out = s2_q;

endmodule

// File: rtl/avr_gpio_port.sv
// rtl/avr_gpio_port.sv - memory-mapped GPIO port with PIN toggle and masked pin-change interrupt
module avr_gpio_port
    import avr_gpio_port_pkg::*;
#(
    parameter int         WIDTH     = 8,
    parameter logic [5:0] BASE_ADDR = PINB_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    avr_gpio_port_if.slave    io,
    input  logic [WIDTH-1:0]  pin_in,
    output logic [WIDTH-1:0]  port_out,
    output logic [WIDTH-1:0]  ddr_out,
    output logic              pc_irq,
    input  logic              pc_ack
);

    logic [WIDTH-1:0] port_q, port_d;
    logic [WIDTH-1:0] ddr_q, ddr_d;
    logic [WIDTH-1:0] pcmsk_q, pcmsk_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             pcif_q, pcif_d;

    logic [WIDTH-1:0] pin_sync;
    logic [5:0]       offset;
    logic             hit;
    io_reg_e          reg_sel;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] change;
    logic             pc_set;
    logic             pc_clr;
    logic [7:0]       rdata;

    avr_gpio_port_sync #(.WIDTH(WIDTH)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pin_in),
        .sync_out (pin_sync)
    );

    assign offset  = io.io_addr - BASE_ADDR;
    assign hit     = reg_hit(offset);
    assign reg_sel = io_reg_e'(offset[2:0]);
    assign wr_en   = io.io_we && hit;
    assign wdata   = io.io_wdata[WIDTH-1:0];

    // Detection ignores ddr on purpose: driven pins loop back through the pads.
    assign change = (pin_sync ^ prev_q) & pcmsk_q;
    assign pc_set = |change;
    assign pc_clr = pc_ack || (wr_en && reg_sel == REG_PCFR && io.io_wdata[PCFR_PCIF_BIT]);

    always_comb begin
        port_d  = port_q;
        ddr_d   = ddr_q;
        pcmsk_d = pcmsk_q;
        prev_d  = pin_sync;
        pcif_d  = pcif_q;

        if (wr_en) begin
            case (reg_sel)
                REG_PIN:   port_d  = port_q ^ wdata;
                REG_DDR:   ddr_d   = wdata;
                REG_PORT:  port_d  = wdata;
                REG_PCMSK: pcmsk_d = wdata;
                default:   ;
            endcase
        end

        // A new event in the clearing cycle must not be lost, so set wins.
        if (pc_set) begin
            pcif_d = 1'b1;
        end else if (pc_clr) begin
            pcif_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            port_q  <= '0;
            ddr_q   <= '0;
            pcmsk_q <= '0;
            prev_q  <= '0;
            pcif_q  <= 1'b0;
        end else begin
            port_q  <= port_d;
            ddr_q   <= ddr_d;
            pcmsk_q <= pcmsk_d;
            prev_q  <= prev_d;
            pcif_q  <= pcif_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (io.io_re && hit) begin
            case (reg_sel)
                REG_PIN:   rdata[WIDTH-1:0] = pin_sync;
                REG_DDR:   rdata[WIDTH-1:0] = ddr_q;
                REG_PORT:  rdata[WIDTH-1:0] = port_q;
                REG_PCMSK: rdata[WIDTH-1:0] = pcmsk_q;
                REG_PCFR:  rdata[PCFR_PCIF_BIT] = pcif_q;
                default:   rdata = '0;
            endcase
        end
    end

    assign io.io_rdata = rdata;
    assign io.io_sel   = hit;
    assign port_out    = port_q;
    assign ddr_out     = ddr_q;
    assign pc_irq      = pcif_q;

endmodule

// File: tb/tb_avr_gpio_port.sv
// tb/tb_avr_gpio_port.sv - directed self-checking bench for avr_gpio_port
module tb_avr_gpio_port;

    localparam logic [5:0] BASE = 6'h16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pin_in;
    logic [7:0] port_out;
    logic [7:0] ddr_out;
    logic       pc_irq;
    logic       pc_ack;

    int n_checks = 0;
    int n_fail   = 0;

    avr_gpio_port_if bus ();

    avr_gpio_port #(.WIDTH(8), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .io       (bus.slave),
        .pin_in   (pin_in),
        .port_out (port_out),
        .ddr_out  (ddr_out),
        .pc_irq   (pc_irq),
        .pc_ack   (pc_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [5:0] addr, input logic [7:0] data);
        bus.io_addr  = addr;
        bus.io_wdata = data;
        bus.io_we    = 1'b1;
        tick();
        bus.io_we    = 1'b0;
    endtask

    task automatic io_read(input logic [5:0] addr, output logic [7:0] data, output logic sel);
        bus.io_addr = addr;
        bus.io_re   = 1'b1;
        #1;
        data = bus.io_rdata;
        sel  = bus.io_sel;
        bus.io_re   = 1'b0;
    endtask

    logic [7:0] rd;
    logic       sel;

    initial begin
        reset        = 1'b0;
        pin_in       = 8'hFF;
        pc_ack       = 1'b0;
        bus.io_addr  = 6'h00;
        bus.io_re    = 1'b0;
        bus.io_we    = 1'b0;
        bus.io_wdata = 8'h00;

        tick();
        tick();
        check("rst_port", port_out, 8'h00);
        check("rst_ddr", ddr_out, 8'h00);
        check("rst_irq", {7'b0, pc_irq}, 8'h00);
        io_read(BASE + 6'd4, rd, sel);
        check("rst_pcfr", rd, 8'h00);

        // Pins are high at release; the resulting edge must stay masked.
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_irq", {7'b0, pc_irq}, 8'h00);

        io_write(BASE + 6'd1, 8'h0F);
        io_write(BASE + 6'd2, 8'hA5);
        check("ddr_out", ddr_out, 8'h0F);
        check("port_out", port_out, 8'hA5);
        io_read(BASE + 6'd1, rd, sel);
        check("rd_ddr", rd, 8'h0F);
        check("sel_hit", {7'b0, sel}, 8'h01);
        io_read(BASE + 6'd2, rd, sel);
        check("rd_port", rd, 8'hA5);
        io_read(BASE + 6'd5, rd, sel);
        check("rd_miss", rd, 8'h00);
        check("sel_miss", {7'b0, sel}, 8'h00);
        io_read(BASE - 6'd1, rd, sel);
        check("sel_below", {7'b0, sel}, 8'h00);
        bus.io_addr = BASE + 6'd2;
        #1;
        check("rd_no_re", bus.io_rdata, 8'h00);

        io_write(BASE, 8'h81);
        check("toggle1", port_out, 8'h24);
        io_write(BASE, 8'h81);
        check("toggle2", port_out, 8'hA5);

        pin_in = 8'h00;
        tick();
        tick();
        tick();
        pin_in = 8'h3C;
        io_read(BASE, rd, sel);
        check("sync_e0", rd, 8'h00);
        tick();
        io_read(BASE, rd, sel);
        check("sync_e1", rd, 8'h00);
        tick();
        io_read(BASE, rd, sel);
        check("sync_e2", rd, 8'h3C);

        io_write(BASE + 6'd3, 8'h04);
        io_read(BASE + 6'd3, rd, sel);
        check("rd_pcmsk", rd, 8'h04);
        tick();
        check("msk_no_evt", {7'b0, pc_irq}, 8'h00);

        pin_in = 8'h34;
        for (int i = 0; i < 4; i++) tick();
        check("unmasked_pin3", {7'b0, pc_irq}, 8'h00);

        pin_in = 8'h30;
        tick();
        check("pc_e1", {7'b0, pc_irq}, 8'h00);
        tick();
        check("pc_e2", {7'b0, pc_irq}, 8'h00);
        tick();
        check("pc_e3", {7'b0, pc_irq}, 8'h01);
        io_read(BASE + 6'd4, rd, sel);
        check("rd_pcfr_set", rd, 8'h01);
        io_write(BASE + 6'd4, 8'h00);
        check("pcfr_wr0", {7'b0, pc_irq}, 8'h01);
        io_write(BASE + 6'd4, 8'h01);
        check("pcfr_clr", {7'b0, pc_irq}, 8'h00);

        pin_in = 8'h34;
        tick();
        tick();
        tick();
        check("pc_again", {7'b0, pc_irq}, 8'h01);
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        check("ack_clr", {7'b0, pc_irq}, 8'h00);

        // Set and ack land on the same edge: the flag must survive.
        pin_in = 8'h30;
        tick();
        tick();
        tick();
        check("sbc_pre", {7'b0, pc_irq}, 8'h01);
        pin_in = 8'h34;
        tick();
        tick();
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        check("set_beats_clr", {7'b0, pc_irq}, 8'h01);
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        check("ack_after", {7'b0, pc_irq}, 8'h00);

        // Read and write together: read sees the old value.
        bus.io_addr  = BASE + 6'd2;
        bus.io_wdata = 8'h3C;
        bus.io_we    = 1'b1;
        bus.io_re    = 1'b1;
        #1;
        check("rw_old", bus.io_rdata, 8'hA5);
        tick();
        bus.io_we = 1'b0;
        bus.io_re = 1'b0;
        check("rw_new", port_out, 8'h3C);

        pin_in = 8'h30;
        tick();
        tick();
        tick();
        check("pre_midrst", {7'b0, pc_irq}, 8'h01);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_irq", {7'b0, pc_irq}, 8'h00);
        check("midrst_port", port_out, 8'h00);
        check("midrst_ddr", ddr_out, 8'h00);
        tick();
        tick();
        tick();
        check("midrst_masked", {7'b0, pc_irq}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
